// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// Iterative 32-step MULTU/DIVU engine for the EXECUTE stage; owns HI/LO
// and requests a pipeline stall while an operation is in flight.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PW-1:0]    p_q,     p_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             mul_q,   mul_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             dbz_q,   dbz_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;

    // One shift-add multiply step: P[63:32] += A when P[0], then shift right.
    logic [WIDTH:0]   mul_sum;
    logic [PW-1:0]    mul_next;

    // One restoring divide step on {R, Q}; R lives in p_q[63:32], Q in p_q[31:0].
    logic [WIDTH:0]   div_rem_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [PW-1:0]    div_next;
    logic [PW-1:0]    step_next;

    always_comb begin
        mul_sum    = {1'b0, p_q[PW-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_next   = {mul_sum, p_q[WIDTH-1:1]};

        div_rem_sh = p_q[PW-1:WIDTH-1];
        div_ge     = (div_rem_sh >= {1'b0, b_q});
        div_diff   = div_rem_sh[WIDTH-1:0] - b_q;
        div_next   = div_ge ? {div_diff,               p_q[WIDTH-2:0], 1'b1}
                            : {div_rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};

        step_next  = mul_q ? mul_next : div_next;
    end

    // Next-state and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        b_d     = b_q;
        mul_d   = mul_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    unique case (op)
                        OP_MULTU: begin
                            p_d     = {{WIDTH{1'b0}}, opb};
                            b_d     = opa;
                            mul_d   = 1'b1;
                            cnt_d   = '0;
                            dbz_d   = 1'b0;
                            busy_d  = 1'b1;
                            state_d = S_RUN;
                        end
                        OP_DIVU: begin
                            p_d     = {{WIDTH{1'b0}}, opa};
                            b_d     = opb;
                            mul_d   = 1'b0;
                            cnt_d   = '0;
                            dbz_d   = 1'b0;
                            busy_d  = 1'b1;
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = opa;
                        OP_MTLO: lo_d = opa;
                        default: ;
                    endcase
                end
            end

            S_RUN: begin
                if (flush) begin
                    // Squashed: drop the partial result, HI/LO/dbz untouched.
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    p_d   = step_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        hi_d    = step_next[PW-1:WIDTH];
                        lo_d    = step_next[WIDTH-1:0];
                        done_d  = 1'b1;
                        dbz_d   = !mul_q && (b_q == '0);
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            b_q     <= '0;
            mul_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            b_q     <= b_d;
            mul_q   <= mul_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign dbz   = dbz_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    // Holds the instruction in EXECUTE until the running operation retires.
    assign stall = busy_q & (start | hilo_rd);

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
// Bench for muldiv_sequencer: vector table with a done-driven scoreboard,
// plus directed stall, flush and mid-operation reset sequences.
module tb_muldiv_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        hilo_rd;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .op      (op),
        .opa     (opa),
        .opb     (opb),
        .hilo_rd (hilo_rd),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .dbz     (dbz),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic        m_dbz = 1'b0;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        if (o == 2'b00) begin
            p     = {32'b0, a} * {32'b0, b};
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.dbz = 1'b0;
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else begin
            e.hi  = a % b;
            e.lo  = a / b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pulse retires the oldest outstanding operation.
    always @(negedge CLK) begin
        if (RST && done) begin
            if (sb_q.size() == 0) begin
                check("done_without_op", 64'(done), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_hi", 64'(hi), 64'(mon_e.hi));
                check("result_lo", 64'(lo), 64'(mon_e.lo));
                check("result_dbz", 64'(dbz), 64'(mon_e.dbz));
                m_hi  = mon_e.hi;
                m_lo  = mon_e.lo;
                m_dbz = mon_e.dbz;
            end
        end
    end

    // Called #1 after an edge with the DUT idle (or in its done cycle);
    // returns #1 after the completing edge, i.e. in the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed);
        int n;
        exp_t e;
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        e.hi  = eh;
        e.lo  = el;
        e.dbz = ed;
        sb_q.push_back(e);
        @(posedge CLK); #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            check("hilo_hidden_hi", 64'(hi), 64'(m_hi));
            check("hilo_hidden_lo", 64'(lo), 64'(m_lo));
            n++;
            @(posedge CLK); #1;
        end
        check("busy_cycles", 64'(n), 64'd32);
        check("done_pulse", 64'(done), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b01, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[2] = '{2'b01, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{2'b00, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0};
        vecs[4] = '{2'b01, 32'd7,         32'd100,       32'd7,         32'd0,         1'b0};
        vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[6] = '{2'b00, 32'd0,         32'hDEAD_BEEF, 32'd0,         32'd0,         1'b0};
        vecs[7] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
        for (int i = 8; i < NVEC; i++) begin
            vecs[i].op = 2'(i & 1);
            vecs[i].a  = $urandom();
            vecs[i].b  = $urandom_range(1, 32'hFFFF);
            e = model(vecs[i].op, vecs[i].a, vecs[i].b);
            vecs[i].exp_hi  = e.hi;
            vecs[i].exp_lo  = e.lo;
            vecs[i].exp_dbz = e.dbz;
        end

        RST     = 1'b0;
        start   = 1'b1;
        op      = 2'b00;
        opa     = '0;
        opb     = '0;
        hilo_rd = 1'b1;
        flush   = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(dbz), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        start   = 1'b0;
        hilo_rd = 1'b0;
        #10 RST = 1'b1;
        @(posedge CLK); #1;

        // Table, issued back-to-back in each done cycle.
        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);
        @(posedge CLK); #1;
        check("done_one_cycle", 64'(done), 64'd0);

        // MULTU 3*5 with MFHI and a pending MTHI held in EXECUTE.
        e = model(2'b00, 32'd3, 32'd5);
        sb_q.push_back(e);
        start = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd5;
        @(posedge CLK); #1;
        op = 2'b10; opa = 32'h0000_00AA; hilo_rd = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            check("stall_while_busy", 64'(stall), 64'd1);
            n++;
            @(posedge CLK); #1;
        end
        check("stall_busy_cycles", 64'(n), 64'd32);
        check("stall_done_cycle", 64'(stall), 64'd0);
        check("stall_done_pulse", 64'(done), 64'd1);
        @(posedge CLK); #1;
        start = 1'b0; hilo_rd = 1'b0;
        m_hi = 32'h0000_00AA;
        check("mthi_after_stall_hi", 64'(hi), 64'h0000_00AA);
        check("mthi_after_stall_lo", 64'(lo), 64'd15);
        check("mthi_busy", 64'(busy), 64'd0);

        // Flush a DIVU in its 10th RUN cycle.
        start = 1'b1; op = 2'b10; opa = 32'd1;
        @(posedge CLK); #1;
        op = 2'b11; opa = 32'd2;
        @(posedge CLK); #1;
        start = 1'b0;
        m_hi = 32'd1; m_lo = 32'd2;
        check("pre_flush_hi", 64'(hi), 64'd1);
        check("pre_flush_lo", 64'(lo), 64'd2);
        start = 1'b1; op = 2'b01; opa = 32'd100; opb = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge CLK); #1;
        end
        check("busy_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        repeat (40) begin
            @(posedge CLK); #1;
        end
        check("flush_hi", 64'(hi), 64'd1);
        check("flush_lo", 64'(lo), 64'd2);
        check("flush_dbz", 64'(dbz), 64'(m_dbz));

        // MTLO squashed by flush in IDLE, then accepted.
        start = 1'b1; op = 2'b11; opa = 32'h55; flush = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; flush = 1'b0;
        check("mtlo_flushed_lo", 64'(lo), 64'd2);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        m_lo = 32'h55;
        check("mtlo_lo", 64'(lo), 64'h55);
        check("mtlo_busy", 64'(busy), 64'd0);

        // Reset in the middle of a MULTU, with dbz and HI/LO non-zero beforehand.
        run_op(2'b01, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        @(posedge CLK); #1;
        start = 1'b1; op = 2'b00; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
        sb_q.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge CLK); #1;
        end
        check("busy_before_rst", 64'(busy), 64'd1);
        RST = 1'b0;
        #1;
        sb_q.delete();
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_dbz", 64'(dbz), 64'd0);
        @(posedge CLK);
        #3 RST = 1'b1;
        @(posedge CLK); #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        @(posedge CLK); #1;
        check("final_done_low", 64'(done), 64'd0);
        check("final_lo", 64'(lo), 64'd42);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
